// File: rtl/ppi_pkg.sv
// Shared constants and types for the PPI port slice.
package ppi_pkg;

  localparam logic PPI_MODE0   = 1'b0;
  localparam logic PPI_MODE1   = 1'b1;
  localparam logic PPI_DIR_IN  = 1'b1;
  localparam logic PPI_DIR_OUT = 1'b0;

  typedef enum logic {
    HS_EMPTY = 1'b0,
    HS_FULL  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/ppi_edge_sync.sv
// Synchroniser plus edge detector for an asynchronous active-low strobe.
// level is registered; fall_c/rise_c are single-cycle pulses decoded from it.
module ppi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall_c,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // synchroniser chain and edge-detect history, idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign fall_c = prev_q & ~level;
  assign rise_c = ~prev_q & level;

endmodule

// File: rtl/ppi_strobed_port.sv
// 8255-style port slice: Mode 0 latched I/O and Mode 1 strobed handshake.
// Optional interrupt logic is built when PPI_PORT_INTR_EN is defined;
// otherwise intr is tied low and inte_set/inte_clr are ignored.
module ppi_strobed_port
  import ppi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic [WIDTH-1:0] bus_din,
  output logic [WIDTH-1:0] bus_dout,
  output logic             bus_oe,
  input  logic             cfg_load,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic             inte_set,
  input  logic             inte_clr,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic             pin_oe,
  input  logic             stb_n,
  output logic             ibf,
  input  logic             ack_n,
  output logic             obf_n,
  output logic             intr
);

  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  hs_state_t        state_q, state_d;
  logic [WIDTH-1:0] in_latch_q, in_latch_d;
  logic [WIDTH-1:0] out_latch_d;
  logic             ibf_d, obf_n_d, pin_oe_d;
  logic             rd_n_q, wr_n_q;
  logic             rd_fall, rd_rise, wr_fall, wr_rise;
  logic             stb_lvl, stb_fall, stb_rise;
  logic             ack_lvl, ack_fall, ack_rise;
  logic             unused_lvl;

  ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (stb_n),
    .level  (stb_lvl),
    .fall_c (stb_fall),
    .rise_c (stb_rise)
  );

  ppi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ack_n),
    .level  (ack_lvl),
    .fall_c (ack_fall),
    .rise_c (ack_rise)
  );

  assign unused_lvl = &{1'b0, stb_lvl, ack_lvl};

  // bus strobe edges, qualified by the port select
  assign rd_fall = sel & rd_n_q & ~rd_n;
  assign rd_rise = sel & ~rd_n_q & rd_n;
  assign wr_fall = sel & wr_n_q & ~wr_n;
  assign wr_rise = sel & ~wr_n_q & wr_n;

  // read path is combinational; only an input port drives the bus
  assign bus_dout = in_latch_q;
  assign bus_oe   = sel & ~rd_n & (dir_q == PPI_DIR_IN);

  // next-state for configuration, latches and handshake flags
  always_comb begin
    mode_d      = mode_q;
    dir_d       = dir_q;
    state_d     = state_q;
    in_latch_d  = in_latch_q;
    out_latch_d = pin_out;
    ibf_d       = ibf;
    obf_n_d     = obf_n;
    pin_oe_d    = pin_oe;
    if (cfg_load) begin
      mode_d      = cfg_mode;
      dir_d       = cfg_dir;
      state_d     = HS_EMPTY;
      in_latch_d  = '0;
      out_latch_d = '0;
      ibf_d       = 1'b0;
      obf_n_d     = 1'b1;
      pin_oe_d    = ~cfg_dir;
    end else begin
      if ((dir_q == PPI_DIR_OUT) && wr_rise) begin
        out_latch_d = bus_din;
      end
      if (mode_q == PPI_MODE0) begin
        if (dir_q == PPI_DIR_IN) begin
          in_latch_d = pin_in;
        end
      end else if (dir_q == PPI_DIR_IN) begin
        if (rd_rise) begin
          ibf_d   = 1'b0;
          state_d = HS_EMPTY;
        end
        // a strobe in the same cycle as read completion keeps the new data
        if (stb_fall) begin
          in_latch_d = pin_in;
          ibf_d      = 1'b1;
          state_d    = HS_FULL;
        end
      end else begin
        if (ack_fall) begin
          obf_n_d = 1'b1;
          state_d = HS_EMPTY;
        end
        if (wr_rise) begin
          obf_n_d = 1'b0;
          state_d = HS_FULL;
        end
      end
    end
  end

  // main state registers; reset leaves a Mode 0 input port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= PPI_MODE0;
      dir_q      <= PPI_DIR_IN;
      state_q    <= HS_EMPTY;
      in_latch_q <= '0;
      pin_out    <= '0;
      ibf        <= 1'b0;
      obf_n      <= 1'b1;
      pin_oe     <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      state_q    <= state_d;
      in_latch_q <= in_latch_d;
      pin_out    <= out_latch_d;
      ibf        <= ibf_d;
      obf_n      <= obf_n_d;
      pin_oe     <= pin_oe_d;
      rd_n_q     <= rd_n;
      wr_n_q     <= wr_n;
    end
  end

`ifdef PPI_PORT_INTR_EN
  logic inte_q, inte_d;
  logic intr_d;

  // interrupt enable and request; clearing inte drops intr at once
  always_comb begin
    inte_d = inte_q;
    intr_d = intr;
    if (cfg_load) begin
      inte_d = 1'b0;
      intr_d = 1'b0;
    end else begin
      if (mode_q == PPI_MODE1) begin
        if (dir_q == PPI_DIR_IN) begin
          if (rd_fall) intr_d = 1'b0;
          if (stb_rise && (state_q == HS_FULL) && inte_q) intr_d = 1'b1;
        end else begin
          if (wr_fall) intr_d = 1'b0;
          if (ack_rise && inte_q) intr_d = 1'b1;
        end
      end
      if (inte_set) inte_d = 1'b1;
      if (inte_clr) begin
        inte_d = 1'b0;
        intr_d = 1'b0;
      end
    end
  end

  // interrupt registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inte_q <= 1'b0;
      intr   <= 1'b0;
    end else begin
      inte_q <= inte_d;
      intr   <= intr_d;
    end
  end
`else
  logic unused_intr;

  assign intr        = 1'b0;
  assign unused_intr = &{1'b0, inte_set, inte_clr, rd_fall, wr_fall, stb_rise, ack_rise};
`endif

endmodule

// File: doc/ppi_strobed_port.md
# ppi_strobed_port

Parametrised PPI port with 8255-style Mode 0 (basic latched I/O) and Mode 1 (strobed I/O with handshake and interrupt). It replaces the purely combinational port slice. It sits between the CPU data-bus decode (chip select, address and control-word decode live outside) and one external port pin group. All state is clocked, with synchronised handshake inputs.

## Interface
- WIDTH, 8, port and data-bus width in bits
- SYNC_STAGES, 2, synchroniser depth for stb_n/ack_n (minimum 2)
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- sel  in  1  this port addressed (cs_n low and address match, decoded outside)
- rd_n, wr_n  in  1 each  bus strobes, active low, synchronous to clk
- bus_din  in  WIDTH  CPU write data
- bus_dout  out  WIDTH  CPU read data
- bus_oe  out  1  drive enable for bus_dout
- cfg_load  in  1  one-cycle pulse: load mode/direction
- cfg_mode  in  1  0 = Mode 0, 1 = Mode 1
- cfg_dir  in  1  1 = input port, 0 = output port
- inte_set, inte_clr  in  1 each  interrupt-enable bit set/clear pulses
- pin_in  in  WIDTH  pad input
- pin_out  out  WIDTH  pad output value
- pin_oe  out  1  pad output enable
- stb_n  in  1  Mode 1 input strobe, asynchronous
- ibf  out  1  input buffer full
- ack_n  in  1  Mode 1 output acknowledge, asynchronous
- obf_n  out  1  output buffer full, active low
- intr  out  1  interrupt request

## Operation
- Reset or cfg_load clears the block:
  - in_latch = 0, out_latch = 0
  - ibf = 0, obf_n = 1, intr = 0, inte = 0
  - pin_oe = !cfg_dir. Reset uses mode 0 with input direction.
- Read access is rd_n low and sel:
  - bus_oe = 1 combinationally, and only when the port is an input port.
  - bus_dout = in_latch.
- Write completion is the wr_n rising edge with sel. It applies only when the port is an output port and loads out_latch = bus_din.
- pin_out = out_latch at all times. pin_oe = 1 if and only if the port is an output port.
- Mode 0 input: in_latch samples pin_in every cycle through one register. There is no handshake; ibf, obf_n and intr stay at their reset values.
- Mode 1 input (states EMPTY and FULL):
  - Synchronised stb_n falling edge: in_latch = pin_in. The block moves to FULL and sets ibf = 1.
  - Synchronised stb_n rising edge while FULL and inte = 1: intr = 1.
  - rd_n falling edge with sel: intr = 0.
  - rd_n rising edge with sel: ibf = 0 and the block moves to EMPTY.
- Mode 1 output (states EMPTY and FULL):
  - wr_n falling edge with sel: intr = 0.
  - wr_n rising edge with sel: out_latch is loaded, obf_n = 0, and the block moves to FULL.
  - Synchronised ack_n falling edge: obf_n = 1 and the block moves to EMPTY.
  - Synchronised ack_n rising edge while inte = 1: intr = 1.
- inte_set and inte_clr:
  - Both together: inte_clr wins.
  - Clearing inte also clears intr the same cycle.
- Boundary conditions:
  - stb_n edge while FULL: in_latch is overwritten and ibf stays 1. There is no overrun error.
  - A write while FULL overwrites out_latch and obf_n stays 0.
  - ack_n while EMPTY: obf_n stays 1. intr may still set on the rising edge.
  - stb_n falling edge and rd_n rising edge in the same cycle: the strobe wins, so ibf = 1 and the new data is held.
  - Any access while the port is in the opposite direction is ignored.
  - cfg_load mid-handshake aborts the handshake immediately.

## Timing
- stb_n/ack_n pass through a SYNC_STAGES flop synchroniser plus 1 edge-detect flop. The pin edge to ibf/obf_n/intr change latency is SYNC_STAGES+1 clocks (3 by default).
- rd_n/wr_n are sampled once for edge detection. Their effects appear 1 clock after the edge is seen.
- bus_dout and bus_oe are combinational from rd_n, sel and in_latch. They carry zero latency.
- Mode 0 input: a pin_in change is visible on bus_dout after 1 clock.
- All outputs are registered except bus_dout and bus_oe.

## Configuration
- PPI_PORT_INTR_EN:
  - Defined: inte and intr are implemented as described above.
  - Undefined: no INTE register exists, inte_set and inte_clr are ignored, and intr is tied to 0. ibf and obf_n behaviour is unchanged.

## Structure
- Shared package ppi_pkg holds:
  - mode and direction constants (PPI_MODE0, PPI_MODE1, PPI_DIR_IN, PPI_DIR_OUT)
  - the handshake state enum (HS_EMPTY, HS_FULL)
- Sub-module ppi_edge_sync(SYNC_STAGES) is instantiated for stb_n and ack_n. It outputs synchronised level, fall pulse and rise pulse.

## Test plan
- Reset, then Mode 0 output (cfg_load with mode=0, dir=0), then write bus_din=8'hA5 -> pin_out=8'hA5 and pin_oe=1 one clock after wr_n rises. ibf/obf_n/intr stay 0/1/0.
- Mode 0 input with pin_in=8'h3C, then a read -> bus_dout=8'h3C and bus_oe=1 while rd_n is low. bus_oe=0 when sel=0.
- Mode 1 input with inte_set and pin_in=8'h5A, then stb_n pulse -> ibf=1 three clocks after stb_n falls and intr=1 after stb_n rises. The read returns 8'h5A, intr=0 on rd_n low, ibf=0 after rd_n rises.
- Mode 1 output with inte set, write 8'hC3 -> obf_n=0. ack_n pulse -> obf_n=1 after the synchronised fall and intr=1 after the synchronised rise. The next write clears intr.
- Mode 1 input FULL with a second stb_n carrying 8'h11 -> in_latch=8'h11 and ibf stays 1. cfg_load mid-handshake -> ibf=0, intr=0, in_latch=0 the next clock.
- Build without PPI_PORT_INTR_EN and rerun the Mode 1 scenarios -> intr stays 0 and ibf/obf_n sequences are identical.
